// File: rtl/clk_div_pkg.sv
// clk_div_pkg -- shared types and helpers for the programmable clock divider.
//
// Contents:
//   DIV_WIDTH_DEFAULT : default counter / divide-value width
//   DIV_WIDTH_MAX     : width of the configuration fields (widest legal WIDTH)
//   cfg_t             : one divider configuration (divide value, and the
//                       high-time field when CLK_DIV_DUTY_EN is defined)
//   eff_div()         : effective divide value, never below 1
//
// Optional feature macro: CLK_DIV_DUTY_EN adds the duty field to cfg_t.
package clk_div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 20;
    localparam int DIV_WIDTH_MAX     = 32;

    // Fields are held at the maximum width so the package stays independent
    // of the WIDTH parameter; callers zero-extend into them.
    typedef struct packed {
        logic [DIV_WIDTH_MAX-1:0] div;
`ifdef CLK_DIV_DUTY_EN
        logic [DIV_WIDTH_MAX-1:0] duty;
`endif
    } cfg_t;

    // A divide value of 0 would give a one-cycle period with no low phase,
    // so it is treated as 1 (period of 2 cycles).
    function automatic logic [DIV_WIDTH_MAX-1:0] eff_div(input logic [DIV_WIDTH_MAX-1:0] div);
        return (div == '0) ? DIV_WIDTH_MAX'(1) : div;
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// clk_div_cfg -- pending / active configuration shadow registers.
//
// A load strobe parks the configuration in a pending register; it only
// becomes active at a period wrap, so the divider never changes mid-period.
// A load that coincides with the wrap bypasses the pending register.
//
// Ports:
//   in_clk     : clock
//   reset      : synchronous active-high reset (active <= RESET_CFG)
//   wrap       : high in the last cycle of a period (enabled and count == D_eff)
//   cfg_load   : one-cycle strobe capturing cfg_in
//   cfg_in     : requested configuration
//   active     : configuration currently in effect (registered)
//   active_nxt : value active takes at the next edge (for look-ahead logic)
//   cfg_busy   : a loaded configuration is waiting for the next wrap
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter cfg_t RESET_CFG = '0
) (
    input  logic in_clk,
    input  logic reset,
    input  logic wrap,
    input  logic cfg_load,
    input  cfg_t cfg_in,
    output cfg_t active,
    output cfg_t active_nxt,
    output logic cfg_busy
);

    cfg_t pending;

    always_comb begin
        active_nxt = active;
        if (wrap) begin
            if (cfg_load) begin
                active_nxt = cfg_in;
            end else if (cfg_busy) begin
                active_nxt = pending;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            active   <= RESET_CFG;
            pending  <= '0;
            cfg_busy <= 1'b0;
        end else begin
            active <= active_nxt;
            if (wrap) begin
                // Whatever was pending (or bypassing) is applied here.
                cfg_busy <= 1'b0;
            end else if (cfg_load) begin
                pending  <= cfg_in;
                cfg_busy <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog -- programmable clock divider with glitch-free registered output.
//
// The period is D_eff+1 in_clk cycles (D_eff = max(div_active, 1)). out_clk is
// low at the start of each period and high for the last H cycles, where
// H = (D_eff+1)>>1, or min(duty, D_eff) when CLK_DIV_DUTY_EN is defined.
//
// Optional feature macro: CLK_DIV_DUTY_EN (adds cfg_duty and a duty register).
//
// Ports:
//   in_clk     : clock, all state updates on posedge
//   reset      : synchronous active-high reset
//   en         : count enable; when low the counter and outputs hold
//   cfg_load   : one-cycle strobe capturing cfg_div (and cfg_duty)
//   cfg_div    : requested divide value D (period D+1)
//   cfg_duty   : requested high time in cycles (CLK_DIV_DUTY_EN only)
//   out_clk    : divided clock, registered
//   tick       : one-cycle pulse in the last cycle of each period
//   cfg_busy   : a loaded configuration awaits the next wrap
//   div_active : divide value currently in effect
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int               WIDTH     = DIV_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(20'hFFFFF)
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] cfg_duty,
`endif
    output logic             out_clk,
    output logic             tick,
    output logic             cfg_busy,
    output logic [WIDTH-1:0] div_active
);

    localparam int DW = DIV_WIDTH_MAX;

`ifdef CLK_DIV_DUTY_EN
    // Computed one bit wider so RESET_DIV = all-ones does not overflow.
    localparam logic [DW:0] RESET_DUTY = (DW+1)'((DW+1)'(RESET_DIV) + (DW+1)'(1)) >> 1;
    localparam cfg_t RESET_CFG = '{div: DW'(RESET_DIV), duty: RESET_DUTY[DW-1:0]};
`else
    localparam cfg_t RESET_CFG = '{div: DW'(RESET_DIV)};
`endif

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [DW-1:0]    d_eff;
    logic             wrap;
    logic             out_nxt;
    cfg_t             cfg_in;
    cfg_t             act;
    cfg_t             act_nxt;

    // High time for a configuration, one bit wider than the fields so that
    // D_eff+1 is representable for D_eff = all-ones.
    function automatic logic [DW:0] high_time(input cfg_t c);
        logic [DW-1:0] d;
        d = eff_div(c.div);
`ifdef CLK_DIV_DUTY_EN
        return (c.duty < d) ? {1'b0, c.duty} : {1'b0, d};
`else
        return ({1'b0, d} + (DW+1)'(1)) >> 1;
`endif
    endfunction

    // High phase begins at count == D_eff+1-H; never at count 0 since H <= D_eff.
    function automatic logic level_at(input logic [WIDTH-1:0] cnt, input cfg_t c);
        logic [DW:0] thresh;
        thresh = {1'b0, eff_div(c.div)} + (DW+1)'(1) - high_time(c);
        return (DW+1)'(cnt) >= thresh;
    endfunction

    always_comb begin
        cfg_in      = '0;
        cfg_in.div  = DW'(cfg_div);
`ifdef CLK_DIV_DUTY_EN
        cfg_in.duty = DW'(cfg_duty);
`endif
    end

    clk_div_cfg #(
        .RESET_CFG (RESET_CFG)
    ) u_cfg (
        .in_clk     (in_clk),
        .reset      (reset),
        .wrap       (wrap),
        .cfg_load   (cfg_load),
        .cfg_in     (cfg_in),
        .active     (act),
        .active_nxt (act_nxt),
        .cfg_busy   (cfg_busy)
    );

    assign d_eff = eff_div(act.div);
    assign wrap  = en && (DW'(count) == d_eff);

    always_comb begin
        count_nxt = count + WIDTH'(1);
        if (wrap) begin
            count_nxt = '0;
        end
    end

    // out_clk is registered from the next count and next configuration, so
    // the new period's first cycle already uses the newly applied divider.
    assign out_nxt = level_at(count_nxt, act_nxt);

    always_ff @(posedge in_clk) begin
        if (reset) begin
            count   <= '0;
            out_clk <= 1'b0;
        end else if (en) begin
            count   <= count_nxt;
            out_clk <= out_nxt;
        end
    end

    assign tick       = wrap;
    assign div_active = act.div[WIDTH-1:0];

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 20: counter and divide-value width, legal range 2..32.
REQ-002 Parameter RESET_DIV, default 20'hFFFFF: divide value loaded at reset; the period is RESET_DIV+1 in_clk cycles.
REQ-003 in_clk  input  1  the single clock; all state updates on its posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; when low, the counter and all outputs hold.
REQ-006 cfg_load  input  1  one-cycle strobe that captures cfg_div (and cfg_duty when built) as the pending configuration.
REQ-007 cfg_div  input  WIDTH  requested divide value D; the period is D+1 cycles.
REQ-008 cfg_duty  input  WIDTH  requested high-time in cycles; present only with CLK_DIV_DUTY_EN.
REQ-009 out_clk  output  1  divided clock, registered.
REQ-010 tick  output  1  one-cycle pulse on each period wrap.
REQ-011 cfg_busy  output  1  high while a loaded configuration awaits application.
REQ-012 div_active  output  WIDTH  divide value currently in effect.

Function
REQ-013 Effective divide value: D_eff = max(div_active, 1); the minimum period is 2 cycles.
REQ-014 Counter count: while en=1, count increments by 1 each cycle; when count == D_eff, count wraps to 0.
REQ-015 While en=0, count, out_clk, tick state and div_active hold; tick=0.
REQ-016 High-time H: without the macro, H = (D_eff+1)>>1, i.e. the high phase is the floor half of the period.
REQ-017 out_clk equals (count >= D_eff+1-H), evaluated on the current count, and is driven from a flop fed by the next-count value, so it has no combinational glitches.
REQ-018 Consequence of REQ-017: out_clk is low in the first part of the period and high in the last H cycles.
REQ-019 tick is 1 exactly in the cycle where en=1 and count == D_eff.
REQ-020 A cfg_load strobe writes the pending register and sets cfg_busy from the next cycle; a second load while busy overwrites the pending value.
REQ-021 The pending value is applied at the wrap (the tick cycle): div_active updates, the new period starts at count=0, and cfg_busy clears in the same edge.
REQ-022 Simultaneous load and wrap: the incoming cfg_div bypasses the pending register and applies at that wrap; cfg_busy stays 0.
REQ-023 A configuration never changes mid-period; out_clk never produces a runt pulse.
REQ-024 A load while en=0 stays pending until the first wrap after en returns high.

Reset
REQ-025 On reset=1 at a posedge: count=0, out_clk=0, tick=0, cfg_busy=0, div_active=RESET_DIV, pending value cleared.
REQ-026 Reset overrides en and cfg_load in the same cycle, and discards any pending load.
REQ-027 The first enabled cycle after reset counts 0 -> 1.

Configuration
REQ-028 With `define CLK_DIV_DUTY_EN:
- the cfg_duty port exists and is captured and applied with cfg_div (same pending/bypass rules);
- H = min(duty_active, D_eff);
- duty_active=0 gives out_clk constant 0;
- the reset value of duty_active is (RESET_DIV+1)>>1.
REQ-029 Without CLK_DIV_DUTY_EN: no cfg_duty port and no duty register; H follows REQ-016.

Structure
REQ-030 Package clk_div_pkg holds:
- DIV_WIDTH_DEFAULT;
- the cfg_t struct (div and, under the macro, duty fields);
- the function eff_div() implementing REQ-013.
REQ-031 Sub-module clk_div_cfg implements the pending/active shadow registers and cfg_busy; the counter and out_clk logic stay in clk_div_prog.

Verification
REQ-032 WIDTH=20, reset then en=1, no load: out_clk low 524288 cycles then high 524288 cycles; tick every 1048576 cycles.
REQ-033 Load cfg_div=4 mid-period: cfg_busy high until the next tick; after it, period=5, out_clk pattern 0,0,0,1,1, tick at count 4.
REQ-034 cfg_div=0 loaded: period=2, out_clk alternates 0,1; cfg_div=1 gives the same pattern.
REQ-035 cfg_load asserted in the tick cycle with cfg_div=2: the next period is 3 cycles immediately, and cfg_busy is never asserted.
REQ-036 en dropped for 7 cycles at count=3 (D=9): count, out_clk and div_active frozen, no tick; resumes at count 4 and the period totals 17 cycles.
REQ-037 With CLK_DIV_DUTY_EN, D=9, duty=3: out_clk high for counts 7..9 only. duty=15: high for counts 1..9. duty=0: constant 0. Reset asserted mid-period restores REQ-025 values on the next edge.
